rx_frame_decoder: RTL and testbench

Byte-level command decoder that consumes the synchronised receive stream (one byte plus a single-cycle valid strobe per received UART character) in the reference clock domain. It assembles multi-byte command frames and issues register-file writes and reads. Read results are forwarded to the transmit path through a valid/ready handshake. It sits directly downstream of the receive-data synchroniser and upstream of the register file and the TX FIFO.

---
 rtl/rx_frame_decoder_if.sv | 32 +++
 rtl/rx_frame_decoder.sv | 130 +++++++++++++
 tb/tb_rx_frame_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_decoder_if.sv
// Bundles the byte stream, register-file port and TX handshake of rx_frame_decoder.
// The decoder uses the master modport; its environment uses slave.
interface rx_frame_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic                  reg_wr_en;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  frame_err;
  logic                  busy;

  modport master (
    input  rx_data, rx_valid, reg_rd_data, reg_rd_valid, tx_ready,
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, tx_data, tx_valid,
           frame_err, busy
  );

  modport slave (
    output rx_data, rx_valid, reg_rd_data, reg_rd_valid, tx_ready,
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, tx_data, tx_valid,
           frame_err, busy
  );
endinterface

// File: rtl/rx_frame_decoder.sv
// Assembles 0xAA/0xBB command frames from the RX byte stream into register writes
// and reads; read data is returned over the TX valid/ready handshake.
module rx_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input logic            CLK,
  input logic            RST,
  rx_frame_decoder_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  txv_q, txv_d;
  logic                  err_q, err_d;
  logic                  addr_ok, timed, expire;

  assign addr_ok = (bus.rx_data >> ADDR_WIDTH) == '0;
  assign timed   = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);
  // The counter includes the strobe cycle itself, so it holds k in the k-th cycle
  // after a byte; silence expires the frame when it would step to TIMEOUT.
  assign expire  = timed && !bus.rx_valid && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;
    if (expire) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (timed && !bus.rx_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data == CMD_WR) begin
          state_d = WR_ADDR;
          cnt_d   = CNT_W'(1);
        end else if (bus.rx_data == CMD_RD) begin
          state_d = RD_ADDR;
          cnt_d   = CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: if (bus.rx_valid) begin
        if (!addr_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == WR_ADDR) begin
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
          cnt_d   = CNT_W'(1);
        end else begin
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      WR_DATA: if (bus.rx_valid) begin
        wdata_d = bus.rx_data;
        wr_en_d = 1'b1;
        state_d = IDLE;
      end
      RD_WAIT: begin
        err_d = bus.rx_valid;
        if (bus.reg_rd_valid) begin
          txd_d   = bus.reg_rd_data;
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        err_d = bus.rx_valid;
        if (txv_q && bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    txv_d = (state_d == RD_SEND);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.tx_data     = txd_q;
  assign bus.tx_valid    = txv_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_rx_frame_decoder.sv
// Randomized frame-level bench for rx_frame_decoder: the bench models the register
// file contents and expected strobe/pulse cycles from the frame rules.
module tb_rx_frame_decoder;
  localparam int DW = 8, AW = 4, TO = 20;

  logic CLK = 1'b0, RST;
  always #5 CLK = ~CLK;

  rx_frame_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  rx_frame_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.master));

  typedef struct { int c; logic [AW-1:0] a; logic [DW-1:0] d; } ev_t;

  int checks = 0, failures = 0, cyc = 0;
  ev_t wr_q[$], rd_q[$], tx_q[$];
  int  err_q[$], txr_q[$], rdv_q[$];
  int  txv_cycles, busy_cycles, both_en, txd_chg;
  logic txv_prev = 1'b0;
  logic [DW-1:0] txd_prev = '0;
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] exp_mem [16];
  int rd_delay = 3, rdy_delay = 0, vcnt = 0;
  logic [AW-1:0] env_a;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observation at the falling edge, well away from the active edge.
  always @(negedge CLK) begin
    ev_t e;
    if (RST) begin
      if (bus.reg_wr_en) begin
        e.c = cyc; e.a = bus.reg_addr; e.d = bus.reg_wr_data; wr_q.push_back(e);
        env_mem[bus.reg_addr] = bus.reg_wr_data;
      end
      if (bus.reg_rd_en) begin e.c = cyc; e.a = bus.reg_addr; e.d = '0; rd_q.push_back(e); end
      if (bus.tx_valid && bus.tx_ready) begin e.c = cyc; e.a = '0; e.d = bus.tx_data; tx_q.push_back(e); end
      if (bus.tx_valid && !txv_prev) txr_q.push_back(cyc);
      if (bus.frame_err) err_q.push_back(cyc);
      if (bus.tx_valid) txv_cycles++;
      if (bus.busy) busy_cycles++;
      if (bus.reg_wr_en && bus.reg_rd_en) both_en++;
      if (bus.tx_valid && txv_prev && bus.tx_data !== txd_prev) txd_chg++;
    end
    txv_prev = bus.tx_valid;
    txd_prev = bus.tx_data;
  end

  // Register-file responder: read data rd_delay cycles after reg_rd_en.
  initial begin
    bus.reg_rd_valid = 1'b0;
    bus.reg_rd_data  = '0;
    forever begin
      @(posedge CLK); #1;
      if (RST && bus.reg_rd_en) begin
        env_a = bus.reg_addr;
        repeat (rd_delay) @(posedge CLK);
        #1;
        bus.reg_rd_valid = 1'b1;
        bus.reg_rd_data  = env_mem[env_a];
        rdv_q.push_back(cyc);
        @(posedge CLK); #1;
        bus.reg_rd_valid = 1'b0;
        bus.reg_rd_data  = DW'($urandom);
      end
    end
  end

  // TX sink: accepts after tx_valid has been up for rdy_delay cycles.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (bus.tx_valid) begin
        bus.tx_ready = (vcnt >= rdy_delay);
        vcnt++;
      end else begin
        vcnt = 0;
        bus.tx_ready = (rdy_delay == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [DW-1:0] b, output int sc);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    sc = cyc;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = DW'($urandom);
  endtask

  task automatic clear_mon();
    wr_q.delete(); rd_q.delete(); tx_q.delete();
    err_q.delete(); txr_q.delete(); rdv_q.delete();
    txv_cycles = 0; busy_cycles = 0; both_en = 0; txd_chg = 0;
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit && tx_q.size() == 0; i++) tick(1);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.reg_wr_en, bus.reg_rd_en, bus.tx_valid, bus.frame_err, bus.busy} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes: got %b exp 00000",
        {bus.reg_wr_en, bus.reg_rd_en, bus.tx_valid, bus.frame_err, bus.busy});
    end
    checks++;
    if ({bus.reg_addr, bus.reg_wr_data, bus.tx_data} !== '0) begin
      failures++; $display("FAIL reset_data: addr %0h wdata %0h txd %0h exp 0",
        bus.reg_addr, bus.reg_wr_data, bus.tx_data);
    end
  endtask

  task automatic test_write(input int n);
    int s, sd, gap;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin a = 4'h5; d = 8'h3C; gap = 10; end
      else begin a = AW'($urandom); d = DW'($urandom); gap = $urandom_range(1, 12); end
      clear_mon();
      send(8'hAA, s); tick(gap - 1);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b exp 1", bus.busy); end
      send(DW'(a), s); tick(gap - 1);
      send(d, sd); tick(3);
      exp_mem[a] = d;
      checks++;
      if (wr_q.size() != 1 || wr_q[0].c != sd + 1 || wr_q[0].a !== a || wr_q[0].d !== d) begin
        failures++; $display("FAIL wr_strobe: n=%0d cyc=%0d a=%0h d=%0h exp n=1 cyc=%0d a=%0h d=%0h",
          wr_q.size(), wr_q.size() ? wr_q[0].c : -1, wr_q.size() ? wr_q[0].a : 0,
          wr_q.size() ? wr_q[0].d : 0, sd + 1, a, d);
      end
      checks++;
      if (err_q.size() != 0 || rd_q.size() != 0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL wr_side: errs=%0d reads=%0d busy=%b exp 0 0 0",
          err_q.size(), rd_q.size(), bus.busy);
      end
      checks++;
      if (bus.reg_addr !== a || bus.reg_wr_data !== d) begin
        failures++; $display("FAIL wr_hold: a=%0h d=%0h exp a=%0h d=%0h", bus.reg_addr, bus.reg_wr_data, a, d);
      end
    end
  endtask

  task automatic test_read_bp(input int n);
    int s, sa;
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin a = 4'h2; rd_delay = 3; rdy_delay = 5; end
      else begin a = AW'($urandom); rd_delay = $urandom_range(1, 5); rdy_delay = $urandom_range(0, 6); end
      tick(1);
      clear_mon();
      send(8'hBB, s);
      send(DW'(a), sa);
      wait_tx(60);
      tick(2);
      checks++;
      if (rd_q.size() != 1 || rd_q[0].c != sa + 1 || rd_q[0].a !== a) begin
        failures++; $display("FAIL rd_strobe: n=%0d cyc=%0d a=%0h exp n=1 cyc=%0d a=%0h",
          rd_q.size(), rd_q.size() ? rd_q[0].c : -1, rd_q.size() ? rd_q[0].a : 0, sa + 1, a);
      end
      checks++;
      if (txr_q.size() != 1 || rdv_q.size() != 1 || txr_q[0] != rdv_q[0] + 1) begin
        failures++; $display("FAIL rd_txrise: rises=%0d rise=%0d exp one rise at %0d",
          txr_q.size(), txr_q.size() ? txr_q[0] : -1, rdv_q.size() ? rdv_q[0] + 1 : -1);
      end
      checks++;
      if (tx_q.size() != 1 || tx_q[0].d !== exp_mem[a] || txr_q.size() != 1 || tx_q[0].c != txr_q[0] + rdy_delay) begin
        failures++; $display("FAIL rd_accept: n=%0d data=%0h cyc=%0d exp n=1 data=%0h cyc=%0d",
          tx_q.size(), tx_q.size() ? tx_q[0].d : 0, tx_q.size() ? tx_q[0].c : -1,
          exp_mem[a], txr_q.size() ? txr_q[0] + rdy_delay : -1);
      end
      checks++;
      if (txv_cycles != rdy_delay + 1 || txd_chg != 0) begin
        failures++; $display("FAIL rd_hold: tx_valid cycles=%0d data changes=%0d exp %0d 0",
          txv_cycles, txd_chg, rdy_delay + 1);
      end
      checks++;
      if (err_q.size() != 0 || wr_q.size() != 0 || both_en != 0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL rd_side: errs=%0d writes=%0d both=%0d busy=%b exp 0 0 0 0",
          err_q.size(), wr_q.size(), both_en, bus.busy);
      end
    end
  endtask

  task automatic test_illegal(input int n);
    int s;
    logic [DW-1:0] b;
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? 8'h11 : DW'($urandom);
      while (b == 8'hAA || b == 8'hBB) b = DW'($urandom);
      clear_mon();
      send(b, s); tick(2);
      checks++;
      if (err_q.size() != 1 || err_q[0] != s + 1 || busy_cycles != 0) begin
        failures++; $display("FAIL ill_cmd: byte=%0h errs=%0d cyc=%0d busy_cycles=%0d exp 1 cyc=%0d busy 0",
          b, err_q.size(), err_q.size() ? err_q[0] : -1, busy_cycles, s + 1);
      end
      b = (k == 0) ? 8'h15 : DW'($urandom_range(16, 255));
      clear_mon();
      send((k % 2) ? 8'hBB : 8'hAA, s);
      send(b, s); tick(3);
      checks++;
      if (err_q.size() != 1 || err_q[0] != s + 1 || wr_q.size() != 0 || rd_q.size() != 0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL ill_addr: addr=%0h errs=%0d cyc=%0d wr=%0d rd=%0d busy=%b exp 1 cyc=%0d 0 0 0",
          b, err_q.size(), err_q.size() ? err_q[0] : -1, wr_q.size(), rd_q.size(), bus.busy, s + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int s, sd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = 4'h1;
    clear_mon();
    send(8'hAA, s);
    send(DW'(a), s);
    for (int i = 0; i < TO + 10 && err_q.size() == 0; i++) tick(1);
    tick(2);
    checks++;
    if (err_q.size() != 1 || err_q[0] != s + TO || wr_q.size() != 0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL timeout: errs=%0d cyc=%0d wr=%0d busy=%b exp 1 cyc=%0d 0 0",
        err_q.size(), err_q.size() ? err_q[0] : -1, wr_q.size(), bus.busy, s + TO);
    end
    // Longest legal gaps: strobes TO-1 cycles apart still form a frame.
    a = AW'($urandom); d = DW'($urandom);
    clear_mon();
    send(8'hAA, s); tick(TO - 2);
    send(DW'(a), s); tick(TO - 2);
    send(d, sd); tick(3);
    exp_mem[a] = d;
    checks++;
    if (err_q.size() != 0 || wr_q.size() != 1 || wr_q[0].c != sd + 1 || wr_q[0].a !== a || wr_q[0].d !== d) begin
      failures++; $display("FAIL timeout_edge: errs=%0d wr=%0d exp errs=0 one write a=%0h d=%0h at %0d",
        err_q.size(), wr_q.size(), a, d, sd + 1);
    end
  endtask

  task automatic test_stray();
    int s, sa, st;
    logic [AW-1:0] a;
    a = AW'($urandom);
    rd_delay = 6; rdy_delay = $urandom_range(0, 3);
    tick(1);
    clear_mon();
    send(8'hBB, s);
    send(DW'(a), sa);
    tick(2);
    send(DW'($urandom), st);
    wait_tx(60);
    tick(2);
    checks++;
    if (err_q.size() != 1 || err_q[0] != st + 1) begin
      failures++; $display("FAIL stray_err: errs=%0d cyc=%0d exp 1 cyc=%0d",
        err_q.size(), err_q.size() ? err_q[0] : -1, st + 1);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0].d !== exp_mem[a] || rd_q.size() != 1 || wr_q.size() != 0) begin
      failures++; $display("FAIL stray_read: tx=%0d data=%0h rd=%0d wr=%0d exp 1 %0h 1 0",
        tx_q.size(), tx_q.size() ? tx_q[0].d : 0, rd_q.size(), wr_q.size(), exp_mem[a]);
    end
  endtask

  task automatic test_back_to_back(input int n);
    int s, sa;
    int sd [$];
    logic [AW-1:0] aq [$];
    logic [DW-1:0] dq [$];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int ok;
    rd_delay = 1; rdy_delay = 0;
    tick(1);
    clear_mon();
    for (int k = 0; k < n; k++) begin
      a = AW'($urandom); d = DW'($urandom);
      send(8'hAA, s); send(DW'(a), s); send(d, s);
      sd.push_back(s); aq.push_back(a); dq.push_back(d);
      exp_mem[a] = d;
    end
    send(8'hBB, s);
    send(DW'(aq[n-1]), sa);
    wait_tx(30);
    tick(2);
    ok = (wr_q.size() == n);
    for (int k = 0; k < n && ok; k++)
      if (wr_q[k].c != sd[k] + 1 || wr_q[k].a !== aq[k] || wr_q[k].d !== dq[k]) ok = 0;
    checks++;
    if (!ok || err_q.size() != 0) begin
      failures++; $display("FAIL b2b_writes: writes=%0d errs=%0d exp %0d writes at data+1, 0 errs",
        wr_q.size(), err_q.size(), n);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0].d !== exp_mem[aq[n-1]] || rd_q.size() != 1 || rd_q[0].c != sa + 1) begin
      failures++; $display("FAIL b2b_read: tx=%0d data=%0h rd=%0d exp 1 %0h 1",
        tx_q.size(), tx_q.size() ? tx_q[0].d : 0, rd_q.size(), exp_mem[aq[n-1]]);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_mon();
    send(8'hAA, s);
    send(8'h04, s);
    RST = 1'b0;
    tick(1);
    checks++;
    if ({bus.reg_addr, bus.reg_wr_data, bus.tx_data, bus.reg_wr_en, bus.reg_rd_en,
         bus.tx_valid, bus.frame_err, bus.busy} !== '0) begin
      failures++; $display("FAIL rst_mid: addr=%0h wdata=%0h busy=%b exp all 0",
        bus.reg_addr, bus.reg_wr_data, bus.busy);
    end
    tick(1);
    RST = 1'b1;
    tick(2);
    send(8'h99, s);
    tick(3);
    checks++;
    if (err_q.size() != 1 || err_q[0] != s + 1 || wr_q.size() != 0 || rd_q.size() != 0) begin
      failures++; $display("FAIL rst_after: errs=%0d cyc=%0d wr=%0d rd=%0d exp 1 cyc=%0d 0 0",
        err_q.size(), err_q.size() ? err_q[0] : -1, wr_q.size(), rd_q.size(), s + 1);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) begin v = DW'($urandom); env_mem[i] = v; exp_mem[i] = v; end
    RST = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    tick(3);
    test_reset();
    RST = 1'b1;
    tick(2);
    test_write(8);
    test_read_bp(8);
    test_illegal(6);
    test_timeout();
    test_stray();
    test_back_to_back(4);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
